card_match_judge: RTL and testbench



---
 rtl/card_pkg.sv | 38 +++
 rtl/card_match_judge_hold_timer.sv | 62 ++++++
 rtl/card_match_judge.sv | 254 +++++++++++++++++++++++++
 tb/tb_card_match_judge.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// ---------------------------------------------------------------------------
// card_pkg
// Shared definitions for the memory-card game judge: card/face geometry, the
// "no card selected" index encoding, the judge FSM state type and small
// helpers for one-hot masks and deck face lookup.
// ---------------------------------------------------------------------------
package card_pkg;

  localparam logic [4:0] NO_CARD   = 5'd16;
  localparam int         NUM_CARDS = 16;
  localparam int         FACE_W    = 4;
  localparam logic [3:0] NUM_PAIRS = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_SHOW    = 2'd2,
    ST_WIN     = 2'd3
  } state_e;

  // One-hot mask for a card index; the "none" encoding maps to an empty mask.
  function automatic logic [NUM_CARDS-1:0] card_onehot(input logic [4:0] idx);
    logic [NUM_CARDS-1:0] oh;
    if (idx < NO_CARD) begin
      oh = 16'b1 << idx[3:0];
    end else begin
      oh = 16'b0;
    end
    return oh;
  endfunction

  // Face value of card idx, packed as deck[4*idx+3 : 4*idx].
  function automatic logic [FACE_W-1:0] face_of(input logic [NUM_CARDS*FACE_W-1:0] deck,
                                                input logic [3:0]                  idx);
    return deck[{idx, 2'b00} +: FACE_W];
  endfunction

endpackage

// File: rtl/card_match_judge_hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
// Loadable down-counter for display delays. After load_i with value N the
// timer runs N+1 cycles (N, N-1, ..., 0) and raises done_o for exactly one
// cycle while it sits at 0, then goes idle until the next load.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset (timer idle, count 0)
//   load_i     : load load_val_i and start running
//   load_val_i : start value of the count-down
//   done_o     : one-cycle pulse in the last cycle of a run
// ---------------------------------------------------------------------------
module hold_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             run_q;
  logic             run_d;

  // Next count: load wins, otherwise count down while running and stop at zero.
  always_comb begin
    count_d = count_q;
    run_d   = run_q;
    if (load_i) begin
      count_d = load_val_i;
      run_d   = 1'b1;
    end else if (run_q) begin
      if (count_q == CNT_ZERO) begin
        run_d = 1'b0;
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end else begin
      count_d = count_q;
      run_d   = run_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= CNT_ZERO;
      run_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      run_q   <= run_d;
    end
  end

  assign done_o = run_q & (count_q == CNT_ZERO);

endmodule

// File: rtl/card_match_judge.sv
// ---------------------------------------------------------------------------
// card_match_judge
// Judges each turn of the memory-card game. A rising edge of C2 latches the
// two chosen indices; one COMPARE cycle rejects illegal pairs or compares the
// two face values; the pair then stays face-up for HOLD_CYCLES cycles (SHOW)
// before it is either committed as matched or turned back down. Once all
// eight pairs are matched the judge parks in WIN until reset.
//   new_clk      : game clock, rising edge
//   rst          : synchronous active-high reset
//   choose_1/2   : chosen card indices (0-15, 16 = none)
//   C2           : "two cards chosen" flag, only its rising edge matters
//   deck         : face values, card i at deck[4i+3:4i]
//   revealed     : face-up mask for the display (includes matched cards)
//   matched      : permanently matched cards
//   pairs_found  : matched pair count 0-8
//   tries        : completed valid comparisons, saturating at 255
//   busy         : high in COMPARE and SHOW
//   result_valid : one-cycle pulse on entry to SHOW
//   result_match : outcome of the last comparison
//   invalid      : one-cycle pulse on a rejected pair
//   win          : sticky until reset
// All outputs are registered.
// ---------------------------------------------------------------------------
module card_match_judge
  import card_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 25_000_000
) (
  input  logic        new_clk,
  input  logic        rst,
  input  logic [4:0]  choose_1,
  input  logic [4:0]  choose_2,
  input  logic        C2,
  input  logic [63:0] deck,
  output logic [15:0] revealed,
  output logic [15:0] matched,
  output logic [3:0]  pairs_found,
  output logic [7:0]  tries,
  output logic        busy,
  output logic        result_valid,
  output logic        result_match,
  output logic        invalid,
  output logic        win
);

  localparam int unsigned      HOLD_W    = $clog2(HOLD_CYCLES + 1);
  // SHOW runs load value + 1 cycles, so loading HOLD_CYCLES-1 gives HOLD_CYCLES.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_e        state_q;
  state_e        state_d;
  logic          c2_q;
  logic          c2_rise_s;
  logic [4:0]    a_q;
  logic [4:0]    a_d;
  logic [4:0]    b_q;
  logic [4:0]    b_d;
  logic [15:0]   matched_q;
  logic [15:0]   matched_d;
  logic [15:0]   revealed_q;
  logic [15:0]   revealed_d;
  logic [3:0]    pairs_q;
  logic [3:0]    pairs_d;
  logic [7:0]    tries_q;
  logic [7:0]    tries_d;
  logic          busy_q;
  logic          busy_d;
  logic          result_valid_q;
  logic          result_valid_d;
  logic          result_match_q;
  logic          result_match_d;
  logic          invalid_q;
  logic          invalid_d;
  logic          win_q;
  logic          win_d;
  logic          reject_s;
  logic          eq_s;
  logic          timer_load_s;
  logic          timer_done_s;

  assign c2_rise_s = C2 & ~c2_q;

  // Out-of-range indices are tested first so the matched[] lookups never matter for them.
  assign reject_s = (a_q >= NO_CARD) | (b_q >= NO_CARD) | (a_q == b_q)
                  | matched_q[a_q[3:0]] | matched_q[b_q[3:0]];
  assign eq_s     = (face_of(deck, a_q[3:0]) == face_of(deck, b_q[3:0]));

  hold_timer #(
    .CNT_W(HOLD_W)
  ) u_hold_timer (
    .clk_i      (new_clk),
    .rst_i      (rst),
    .load_i     (timer_load_s),
    .load_val_i (HOLD_LOAD),
    .done_o     (timer_done_s)
  );

  // FSM state register.
  always_ff @(posedge new_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (c2_rise_s) begin
          state_d = ST_COMPARE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (reject_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (timer_done_s) begin
          if (result_match_q && (pairs_q == (NUM_PAIRS - 4'd1))) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_SHOW;
        end
      end
      ST_WIN: begin
        state_d = ST_WIN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: next values of the registered outputs and datapath.
  always_comb begin
    a_d            = a_q;
    b_d            = b_q;
    matched_d      = matched_q;
    pairs_d        = pairs_q;
    tries_d        = tries_q;
    result_match_d = result_match_q;
    result_valid_d = 1'b0;
    invalid_d      = 1'b0;
    timer_load_s   = 1'b0;
    revealed_d     = 16'h0000;

    case (state_q)
      ST_IDLE: begin
        if (c2_rise_s) begin
          a_d = choose_1;
          b_d = choose_2;
        end else begin
          a_d = a_q;
          b_d = b_q;
        end
      end
      ST_COMPARE: begin
        if (reject_s) begin
          invalid_d = 1'b1;
        end else begin
          if (tries_q != 8'd255) begin
            tries_d = tries_q + 8'd1;
          end else begin
            tries_d = tries_q;
          end
          result_valid_d = 1'b1;
          result_match_d = eq_s;
          timer_load_s   = 1'b1;
        end
      end
      ST_SHOW: begin
        // Commit only when the display time has elapsed; a reset before that drops the pair.
        if (timer_done_s && result_match_q) begin
          matched_d = matched_q | card_onehot(a_q) | card_onehot(b_q);
          pairs_d   = pairs_q + 4'd1;
        end else begin
          matched_d = matched_q;
          pairs_d   = pairs_q;
        end
      end
      ST_WIN: begin
        matched_d = matched_q;
      end
      default: begin
        matched_d = matched_q;
      end
    endcase

    // Display mask follows the state being entered so it lines up with the state.
    case (state_d)
      ST_IDLE:    revealed_d = matched_d | card_onehot(choose_1);
      ST_COMPARE: revealed_d = matched_d | card_onehot(a_d);
      ST_SHOW:    revealed_d = matched_d | card_onehot(a_d) | card_onehot(b_d);
      ST_WIN:     revealed_d = 16'hFFFF;
      default:    revealed_d = 16'h0000;
    endcase

    busy_d = (state_d == ST_COMPARE) || (state_d == ST_SHOW);
    win_d  = (state_d == ST_WIN);
  end

  // Datapath and output registers.
  always_ff @(posedge new_clk) begin
    if (rst) begin
      c2_q           <= 1'b0;
      a_q            <= NO_CARD;
      b_q            <= NO_CARD;
      matched_q      <= 16'h0000;
      revealed_q     <= 16'h0000;
      pairs_q        <= 4'd0;
      tries_q        <= 8'd0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_match_q <= 1'b0;
      invalid_q      <= 1'b0;
      win_q          <= 1'b0;
    end else begin
      c2_q           <= C2;
      a_q            <= a_d;
      b_q            <= b_d;
      matched_q      <= matched_d;
      revealed_q     <= revealed_d;
      pairs_q        <= pairs_d;
      tries_q        <= tries_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_match_q <= result_match_d;
      invalid_q      <= invalid_d;
      win_q          <= win_d;
    end
  end

  assign revealed     = revealed_q;
  assign matched      = matched_q;
  assign pairs_found  = pairs_q;
  assign tries        = tries_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_match = result_match_q;
  assign invalid      = invalid_q;
  assign win          = win_q;

endmodule

// File: tb/tb_card_match_judge.sv
// ---------------------------------------------------------------------------
// tb_card_match_judge
// Directed bench for card_match_judge with HOLD_CYCLES = 4. Inputs change and
// outputs are sampled on the falling clock edge.
// Deck faces (card: face): 0:1 1:2 2:1 3:5 4:2 5:3 6:3 7:4 8:4 9:5
//                          10:6 11:6 12:7 13:7 14:8 15:8
// ---------------------------------------------------------------------------
module tb_card_match_judge;

  localparam int HOLD = 4;

  logic        new_clk = 1'b0;
  logic        rst;
  logic [4:0]  choose_1;
  logic [4:0]  choose_2;
  logic        C2;
  logic [63:0] deck;
  logic [15:0] revealed;
  logic [15:0] matched;
  logic [3:0]  pairs_found;
  logic [7:0]  tries;
  logic        busy;
  logic        result_valid;
  logic        result_match;
  logic        invalid;
  logic        win;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Remaining pairs after (3,9): first card, second card, matched mask afterwards.
  logic [4:0]  p1_tbl   [7] = '{5'd0, 5'd1, 5'd5, 5'd7, 5'd10, 5'd12, 5'd14};
  logic [4:0]  p2_tbl   [7] = '{5'd2, 5'd4, 5'd6, 5'd8, 5'd11, 5'd13, 5'd15};
  logic [15:0] mask_tbl [7] = '{16'h020D, 16'h021F, 16'h027F, 16'h03FF,
                                16'h0FFF, 16'h3FFF, 16'hFFFF};

  card_match_judge #(
    .HOLD_CYCLES(HOLD)
  ) dut (
    .new_clk      (new_clk),
    .rst          (rst),
    .choose_1     (choose_1),
    .choose_2     (choose_2),
    .C2           (C2),
    .deck         (deck),
    .revealed     (revealed),
    .matched      (matched),
    .pairs_found  (pairs_found),
    .tries        (tries),
    .busy         (busy),
    .result_valid (result_valid),
    .result_match (result_match),
    .invalid      (invalid),
    .win          (win)
  );

  // Free-running game clock.
  always #5 new_clk = ~new_clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_revealed"},     revealed,            16'h0000);
    check_eq({tag, "_matched"},      matched,             16'h0000);
    check_eq({tag, "_pairs"},        16'(pairs_found),    16'h0000);
    check_eq({tag, "_tries"},        16'(tries),          16'h0000);
    check_eq({tag, "_busy"},         16'(busy),           16'h0000);
    check_eq({tag, "_result_valid"}, 16'(result_valid),   16'h0000);
    check_eq({tag, "_result_match"}, 16'(result_match),   16'h0000);
    check_eq({tag, "_invalid"},      16'(invalid),        16'h0000);
    check_eq({tag, "_win"},          16'(win),            16'h0000);
  endtask

  // One complete turn; called on a falling edge with c2_q known low.
  task automatic play_turn(input logic [4:0] c1, input logic [4:0] c2,
                           input logic exp_inv, input logic exp_match,
                           input logic [15:0] exp_show, input logic [7:0] exp_tries,
                           input logic [15:0] exp_m, input logic [3:0] exp_p,
                           input int extra_hold);
    choose_1 = c1;
    choose_2 = c2;
    C2       = 1'b1;
    @(negedge new_clk);
    check_eq("busy_compare", 16'(busy), 16'h0001);
    @(negedge new_clk);
    check_eq("invalid", 16'(invalid), 16'(exp_inv));
    check_eq("result_valid", 16'(result_valid), exp_inv ? 16'h0000 : 16'h0001);
    check_eq("tries", 16'(tries), 16'(exp_tries));
    if (!exp_inv) begin
      check_eq("result_match", 16'(result_match), 16'(exp_match));
      check_eq("revealed_show", revealed, exp_show);
      repeat (HOLD - 1) @(negedge new_clk);
      check_eq("busy_show_end", 16'(busy), 16'h0001);
      check_eq("result_valid_pulse", 16'(result_valid), 16'h0000);
      check_eq("revealed_show_end", revealed, exp_show);
      @(negedge new_clk);
    end else begin
      check_eq("busy_after_invalid", 16'(busy), 16'h0000);
    end
    check_eq("busy_done", 16'(busy), 16'h0000);
    check_eq("matched", matched, exp_m);
    check_eq("pairs_found", 16'(pairs_found), 16'(exp_p));
    repeat (extra_hold) @(negedge new_clk);
    check_eq("tries_after_hold", 16'(tries), 16'(exp_tries));
    check_eq("busy_after_hold", 16'(busy), 16'h0000);
    C2 = 1'b0;
    @(negedge new_clk);
    check_eq("invalid_pulse_end", 16'(invalid), 16'h0000);
  endtask

  initial begin
    rst      = 1'b1;
    C2       = 1'b0;
    choose_1 = 5'd16;
    choose_2 = 5'd16;
    deck     = 64'h8877_6654_4332_5121;
    repeat (2) @(negedge new_clk);
    rst = 1'b0;
    check_reset_values("reset");

    // IDLE preview of the first chosen card, then "none".
    choose_1 = 5'd5;
    @(negedge new_clk);
    check_eq("preview_5", revealed, 16'h0020);
    choose_1 = 5'd16;
    @(negedge new_clk);
    check_eq("preview_none", revealed, 16'h0000);

    // Matching pair 3/9, C2 held high about ten cycles: only one comparison.
    play_turn(5'd3, 5'd9, 1'b0, 1'b1, 16'h0208, 8'd1, 16'h0208, 4'd1, 4);

    // Mismatch 0/1 with a second C2 rise during SHOW that must be dropped.
    choose_1 = 5'd0;
    choose_2 = 5'd1;
    C2       = 1'b1;
    @(negedge new_clk);
    @(negedge new_clk);
    check_eq("mm_result_valid", 16'(result_valid), 16'h0001);
    check_eq("mm_result_match", 16'(result_match), 16'h0000);
    check_eq("mm_revealed", revealed, 16'h020B);
    check_eq("mm_tries", 16'(tries), 16'h0002);
    C2 = 1'b0;
    @(negedge new_clk);
    C2 = 1'b1;
    @(negedge new_clk);
    @(negedge new_clk);
    check_eq("mm_busy_show", 16'(busy), 16'h0001);
    @(negedge new_clk);
    check_eq("mm_busy_done", 16'(busy), 16'h0000);
    check_eq("mm_matched", matched, 16'h0208);
    check_eq("mm_revealed_idle", revealed, 16'h0209);
    @(negedge new_clk);
    check_eq("mm_no_second_turn", 16'(busy), 16'h0000);
    check_eq("mm_tries_kept", 16'(tries), 16'h0002);
    C2 = 1'b0;
    @(negedge new_clk);

    // Rejected pairs: same card, already-matched card, out-of-range index.
    play_turn(5'd7,  5'd7, 1'b1, 1'b0, 16'h0000, 8'd2, 16'h0208, 4'd1, 0);
    play_turn(5'd3,  5'd5, 1'b1, 1'b0, 16'h0000, 8'd2, 16'h0208, 4'd1, 0);
    play_turn(5'd16, 5'd5, 1'b1, 1'b0, 16'h0000, 8'd2, 16'h0208, 4'd1, 0);

    // Remaining seven pairs to reach the win condition.
    for (int i = 0; i < 7; i++) begin
      play_turn(p1_tbl[i], p2_tbl[i], 1'b0, 1'b1, mask_tbl[i], 8'(i + 3),
                mask_tbl[i], 4'(i + 2), 0);
    end
    check_eq("win", 16'(win), 16'h0001);
    check_eq("win_revealed", revealed, 16'hFFFF);
    check_eq("win_pairs", 16'(pairs_found), 16'h0008);

    // C2 activity in WIN has no effect.
    choose_1 = 5'd0;
    choose_2 = 5'd1;
    C2       = 1'b1;
    repeat (3) @(negedge new_clk);
    check_eq("win_busy", 16'(busy), 16'h0000);
    check_eq("win_tries", 16'(tries), 16'h0009);
    check_eq("win_result_valid", 16'(result_valid), 16'h0000);
    check_eq("win_sticky", 16'(win), 16'h0001);
    check_eq("win_revealed_kept", revealed, 16'hFFFF);
    C2 = 1'b0;
    @(negedge new_clk);

    // Reset out of WIN, then reset in the middle of a matching SHOW.
    rst = 1'b1;
    @(negedge new_clk);
    rst = 1'b0;
    check_reset_values("rst_win");
    choose_1 = 5'd3;
    choose_2 = 5'd9;
    C2       = 1'b1;
    repeat (3) @(negedge new_clk);
    check_eq("mid_show_busy", 16'(busy), 16'h0001);
    rst      = 1'b1;
    C2       = 1'b0;
    choose_1 = 5'd16;
    choose_2 = 5'd16;
    @(negedge new_clk);
    rst = 1'b0;
    check_reset_values("rst_show");
    repeat (HOLD) @(negedge new_clk);
    check_eq("rst_show_matched_later", matched, 16'h0000);
    check_eq("rst_show_pairs_later", 16'(pairs_found), 16'h0000);
    check_eq("rst_show_busy_later", 16'(busy), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
